ball_draw: RTL and testbench

Ball renderer for the breakout display path. Accepts a new ball position from the ball/collision update logic over a valid/ready handshake. Erases the sprite at the previous position with the background colour, then draws a SIZE×SIZE square at the new position. Writes one pixel per clock into the 160×120 VGA adapter's plot port.

---
 rtl/breakout_pkg.sv | 22 ++
 rtl/rect_scanner.sv | 80 ++++++++
 rtl/ball_draw.sv | 182 ++++++++++++++++++
 tb/tb_ball_draw.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// -----------------------------------------------------------------------------
// breakout_pkg
// Shared definitions for the breakout display path: screen geometry, the
// VGA adapter's coordinate/colour widths and the draw-state encoding used by
// the sprite renderers.
// -----------------------------------------------------------------------------
package breakout_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } draw_state_t;

endpackage

// File: rtl/rect_scanner.sv
// -----------------------------------------------------------------------------
// rect_scanner
// Walks a SIZE x SIZE square in raster order (column inner, row outer), one
// pixel per clock, and presents the absolute pixel address combinationally.
// Shared by every rectangle renderer (ball, paddle, bricks).
//
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   start        issue pixel (0,0) of a new scan this cycle
//   base_x/y     top-left corner of the square being scanned
//   px, py       address of the pixel issued this cycle (9/8 bits, no wrap)
//   in_bounds    issued pixel lies on screen (px < X_MAX, py < Y_MAX)
//   last         issued pixel is the final one of the square
//   valid        a pixel is issued this cycle (start, or scan in progress)
//
// SIZE must be 1..8; the counters are 3 bits wide.
// -----------------------------------------------------------------------------
module rect_scanner
    import breakout_pkg::*;
#(
    parameter int SIZE  = 2,
    parameter int X_MAX = SCREEN_W,
    parameter int Y_MAX = SCREEN_H
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    output logic [X_W:0]   px,
    output logic [Y_W:0]   py,
    output logic           in_bounds,
    output logic           last,
    output logic           valid
);

    localparam logic [2:0]   LAST_C = 3'(SIZE - 1);
    localparam logic [X_W:0] X_LIM  = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM  = (Y_W + 1)'(Y_MAX);

    logic [2:0] cx, cy;
    logic [2:0] cur_cx, cur_cy;
    logic       active;

    // start overrides the counters so pixel (0,0) is issued in the same
    // cycle the scan is requested.
    always_comb begin
        cur_cx    = start ? 3'd0 : cx;
        cur_cy    = start ? 3'd0 : cy;
        valid     = start | active;
        last      = (cur_cx == LAST_C) && (cur_cy == LAST_C);
        px        = {1'b0, base_x} + {{(X_W - 2){1'b0}}, cur_cx};
        py        = {1'b0, base_y} + {{(Y_W - 2){1'b0}}, cur_cy};
        in_bounds = (px < X_LIM) && (py < Y_LIM);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx     <= 3'd0;
            cy     <= 3'd0;
            active <= 1'b0;
        end else if (valid) begin
            if (last) begin
                cx     <= 3'd0;
                cy     <= 3'd0;
                active <= 1'b0;
            end else begin
                active <= 1'b1;
                if (cur_cx == LAST_C) begin
                    cx <= 3'd0;
                    cy <= cur_cy + 3'd1;
                end else begin
                    cx <= cur_cx + 3'd1;
                    cy <= cur_cy;
                end
            end
        end
    end

endmodule

// File: rtl/ball_draw.sv
// -----------------------------------------------------------------------------
// ball_draw
// Ball renderer: accepts a new ball position, erases the sprite at the old
// position with BG_COLOUR, then draws a SIZE x SIZE square of BALL_COLOUR at
// the new position, one pixel per clock into the VGA adapter plot port.
//
// Configuration macro BALL_DRAW_ERASE_EN: when defined, the ERASE pass and the
// old-position registers exist. When undefined, every update draws directly
// and the ball leaves a trail.
//
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   upd_valid       new position offered
//   upd_x, upd_y    new top-left position
//   upd_ready       high only in IDLE
//   vga_x, vga_y    registered pixel address (low bits of the scan address)
//   vga_colour      registered pixel colour
//   vga_plot        registered write strobe, low for clipped pixels
//   done            one-cycle pulse in FINISH
//   dbg_state       current FSM state
//
// Handshake: a transfer happens on a rising edge where upd_valid && upd_ready;
// upd_ready is a decode of the state register only, so it never depends on
// upd_valid. Offered data outside IDLE is ignored.
// -----------------------------------------------------------------------------
module ball_draw
    import breakout_pkg::*;
#(
    parameter int                  SIZE        = 2,
    parameter logic [COLOUR_W-1:0] BALL_COLOUR = 3'b111,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
    parameter int                  X_MAX       = 160,
    parameter int                  Y_MAX       = 120
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                upd_valid,
    input  logic [X_W-1:0]      upd_x,
    input  logic [Y_W-1:0]      upd_y,
    output logic                upd_ready,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                done,
    output draw_state_t         dbg_state
);

    draw_state_t         state;
    logic [X_W-1:0]      new_x;
    logic [Y_W-1:0]      new_y;
    logic                out_last;   // the pixel now on vga_* is the last of its pass
    logic                transfer;
    logic                start;
    logic                issue_erase;
    logic [COLOUR_W-1:0] issue_colour;
    logic [X_W-1:0]      base_x;
    logic [Y_W-1:0]      base_y;

    logic [X_W:0]        scan_px;
    logic [Y_W:0]        scan_py;
    logic                scan_in_bounds;
    logic                scan_last;
    logic                scan_valid;

`ifdef BALL_DRAW_ERASE_EN
    logic [X_W-1:0]      old_x;
    logic [Y_W-1:0]      old_y;
    logic                old_valid;
`endif

    assign upd_ready = (state == IDLE);
    assign dbg_state = state;
    assign transfer  = upd_valid && upd_ready;

    // The scanner issues one pixel ahead of the registered outputs, so the
    // base/colour selection describes the pixel being issued, not the state
    // currently displayed. On the transfer cycle the new position is taken
    // straight from the inputs; it is latched at the same edge.
    always_comb begin
        issue_erase = 1'b0;
        base_x      = new_x;
        base_y      = new_y;
        if (state == IDLE) begin
            base_x = upd_x;
            base_y = upd_y;
        end
`ifdef BALL_DRAW_ERASE_EN
        if (((state == IDLE) && old_valid) || ((state == ERASE) && !out_last)) begin
            issue_erase = 1'b1;
            base_x      = old_x;
            base_y      = old_y;
        end
`endif
        // The second scan starts while the last erase pixel is on the outputs,
        // so DRAW follows ERASE with no gap.
        start        = transfer || ((state == ERASE) && out_last);
        issue_colour = issue_erase ? BG_COLOUR : BALL_COLOUR;
    end

    rect_scanner #(
        .SIZE  (SIZE),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_scanner (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_x    (base_x),
        .base_y    (base_y),
        .px        (scan_px),
        .py        (scan_py),
        .in_bounds (scan_in_bounds),
        .last      (scan_last),
        .valid     (scan_valid)
    );

    // Top address bits only feed the clipping compare inside the scanner.
    logic unused_scan_msbs;
    assign unused_scan_msbs = &{1'b0, scan_px[X_W], scan_py[Y_W]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            new_x      <= '0;
            new_y      <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
            out_last   <= 1'b0;
`ifdef BALL_DRAW_ERASE_EN
            old_x      <= '0;
            old_y      <= '0;
            old_valid  <= 1'b0;
`endif
        end else begin
            vga_plot <= scan_valid && scan_in_bounds;
            out_last <= scan_valid && scan_last;
            done     <= 1'b0;
            if (scan_valid) begin
                vga_x      <= scan_px[X_W-1:0];
                vga_y      <= scan_py[Y_W-1:0];
                vga_colour <= issue_colour;
            end

            case (state)
                IDLE: begin
                    if (transfer) begin
                        new_x <= upd_x;
                        new_y <= upd_y;
`ifdef BALL_DRAW_ERASE_EN
                        state <= old_valid ? ERASE : DRAW;
`else
                        state <= DRAW;
`endif
                    end
                end
                ERASE: begin
                    if (out_last) state <= DRAW;
                end
                DRAW: begin
                    if (out_last) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
`ifdef BALL_DRAW_ERASE_EN
                    old_x     <= new_x;
                    old_y     <= new_y;
                    old_valid <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_draw.sv
// -----------------------------------------------------------------------------
// tb_ball_draw
// Directed bench for ball_draw (SIZE=2). Each cycle after a transfer is
// sampled as {upd_ready, done, vga_plot, vga_colour, vga_x, vga_y} and checked
// against hand-written expected words. Address/colour fields are only checked
// on cycles where a plot is expected. Expectations follow BALL_DRAW_ERASE_EN.
// -----------------------------------------------------------------------------
module tb_ball_draw;
    import breakout_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn    = 1'b0;
    logic        upd_valid = 1'b0;
    logic [7:0]  upd_x     = '0;
    logic [6:0]  upd_y     = '0;
    logic        upd_ready;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        done;
    draw_state_t dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [20:0] exp_q[$];
    logic [20:0] act_q[$];

    ball_draw #(
        .SIZE        (2),
        .BALL_COLOUR (3'b111),
        .BG_COLOUR   (3'b000),
        .X_MAX       (160),
        .Y_MAX       (120)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .upd_valid  (upd_valid),
        .upd_x      (upd_x),
        .upd_y      (upd_y),
        .upd_ready  (upd_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- expected-word builders ----------------
    function automatic logic [20:0] w_draw(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, 1'b0, 1'b1, 3'b111, x, y};
    endfunction
    function automatic logic [20:0] w_erase(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, 1'b0, 1'b1, 3'b000, x, y};
    endfunction
    function automatic logic [20:0] w_clip();
        return {1'b0, 1'b0, 1'b0, 18'd0};
    endfunction
    function automatic logic [20:0] w_done();
        return {1'b0, 1'b1, 1'b0, 18'd0};
    endfunction
    function automatic logic [20:0] w_idle();
        return {1'b1, 1'b0, 1'b0, 18'd0};
    endfunction

    // ---------------- driver ----------------
    // Offers (x,y) until accepted, then records n cycles after the transfer.
    // upd_valid stays high for cycles 1..hold with data (60+k, 70+k).
    task automatic drive_capture(input logic [7:0] x, input logic [6:0] y,
                                 input int n, input int hold);
        int guard;
        guard     = 0;
        upd_valid = 1'b1;
        upd_x     = x;
        upd_y     = y;
        while (upd_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: upd_ready=%b, required 1", upd_ready);
            upd_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            upd_valid = (k <= hold);
            upd_x     = 8'(60 + k);
            upd_y     = 7'(70 + k);
            @(negedge clk);
            act_q.push_back({upd_ready, done, vga_plot, vga_colour, vga_x, vga_y});
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn    = 1'b0;
        upd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({vga_plot, done, vga_colour, vga_x, vga_y} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {vga_plot, done, vga_colour, vga_x, vga_y});
        end
        n_cmp++;
        if (upd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 1", upd_ready);
        end
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_draw();
        logic [20:0] e, a;
        int k;
        exp_q = '{w_draw(10, 20), w_draw(11, 20), w_draw(10, 21), w_draw(11, 21),
                  w_done(), w_idle()};
        drive_capture(8'd10, 7'd20, 6, 0);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() > 0) a = act_q.pop_front(); else a = 'x;
            k++;
            n_cmp++;
            if (a[20:18] !== e[20:18] || (e[18] && a[17:0] !== e[17:0])) begin
                n_fail++;
                $display("FAIL first_draw cyc t+%0d: got %h, required %h", k, a, e);
            end
        end
        act_q.delete();
    endtask

    task automatic test_erase_redraw();
        logic [20:0] e, a;
        int k;
`ifdef BALL_DRAW_ERASE_EN
        exp_q = '{w_erase(10, 20), w_erase(11, 20), w_erase(10, 21), w_erase(11, 21),
                  w_draw(11, 21), w_draw(12, 21), w_draw(11, 22), w_draw(12, 22),
                  w_done(), w_idle()};
        drive_capture(8'd11, 7'd21, 10, 0);
`else
        exp_q = '{w_draw(11, 21), w_draw(12, 21), w_draw(11, 22), w_draw(12, 22),
                  w_done(), w_idle()};
        drive_capture(8'd11, 7'd21, 6, 0);
`endif
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() > 0) a = act_q.pop_front(); else a = 'x;
            k++;
            n_cmp++;
            if (a[20:18] !== e[20:18] || (e[18] && a[17:0] !== e[17:0])) begin
                n_fail++;
                $display("FAIL erase_redraw cyc t+%0d: got %h, required %h", k, a, e);
            end
        end
        act_q.delete();
    endtask

    task automatic test_clip();
        logic [20:0] e, a;
        int k;
`ifdef BALL_DRAW_ERASE_EN
        exp_q = '{w_erase(11, 21), w_erase(12, 21), w_erase(11, 22), w_erase(12, 22),
                  w_draw(159, 119), w_clip(), w_clip(), w_clip(),
                  w_done(), w_idle()};
        drive_capture(8'd159, 7'd119, 10, 0);
`else
        exp_q = '{w_draw(159, 119), w_clip(), w_clip(), w_clip(), w_done(), w_idle()};
        drive_capture(8'd159, 7'd119, 6, 0);
`endif
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() > 0) a = act_q.pop_front(); else a = 'x;
            k++;
            n_cmp++;
            if (a[20:18] !== e[20:18] || (e[18] && a[17:0] !== e[17:0])) begin
                n_fail++;
                $display("FAIL clip cyc t+%0d: got %h, required %h", k, a, e);
            end
        end
        act_q.delete();
    endtask

    // Reset lands two cycles into the scan (ERASE when erase is built in,
    // DRAW otherwise); the next update must draw without an erase pass.
    task automatic test_reset_mid_scan();
        logic [20:0] e, a;
        int k;
`ifdef BALL_DRAW_ERASE_EN
        exp_q = '{w_erase(159, 119), w_clip()};
`else
        exp_q = '{w_draw(30, 40), w_draw(31, 40)};
`endif
        drive_capture(8'd30, 7'd40, 2, 0);
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({vga_plot, done, vga_colour, vga_x, vga_y} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h, required 0",
                     {vga_plot, done, vga_colour, vga_x, vga_y});
        end
        n_cmp++;
        if (upd_ready !== 1'b1 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL mid_reset_ready: ready=%b state=%0d, required ready=1 state=%0d",
                     upd_ready, dbg_state, IDLE);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_q = '{exp_q[0], exp_q[1],
                  w_draw(5, 5), w_draw(6, 5), w_draw(5, 6), w_draw(6, 6),
                  w_done(), w_idle()};
        drive_capture(8'd5, 7'd5, 6, 0);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() > 0) a = act_q.pop_front(); else a = 'x;
            k++;
            n_cmp++;
            if (a[20:18] !== e[20:18] || (e[18] && a[17:0] !== e[17:0])) begin
                n_fail++;
                $display("FAIL reset_mid_scan word %0d: got %h, required %h", k, a, e);
            end
        end
        act_q.delete();
    endtask

    // upd_valid held high with changing data: the scan ignores it and the
    // next transfer takes the data present in the cycle after done.
    task automatic test_back_to_back();
        logic [20:0] e, a;
        int k;
`ifdef BALL_DRAW_ERASE_EN
        exp_q = '{w_erase(5, 5), w_erase(6, 5), w_erase(5, 6), w_erase(6, 6),
                  w_draw(40, 50), w_draw(41, 50), w_draw(40, 51), w_draw(41, 51),
                  w_done(), w_idle(),
                  w_erase(40, 50), w_erase(41, 50), w_erase(40, 51), w_erase(41, 51),
                  w_draw(70, 80), w_draw(71, 80), w_draw(70, 81), w_draw(71, 81),
                  w_done(), w_idle()};
        drive_capture(8'd40, 7'd50, 20, 10);
`else
        exp_q = '{w_draw(40, 50), w_draw(41, 50), w_draw(40, 51), w_draw(41, 51),
                  w_done(), w_idle(),
                  w_draw(66, 76), w_draw(67, 76), w_draw(66, 77), w_draw(67, 77),
                  w_done(), w_idle()};
        drive_capture(8'd40, 7'd50, 12, 6);
`endif
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() > 0) a = act_q.pop_front(); else a = 'x;
            k++;
            n_cmp++;
            if (a[20:18] !== e[20:18] || (e[18] && a[17:0] !== e[17:0])) begin
                n_fail++;
                $display("FAIL back_to_back cyc t+%0d: got %h, required %h", k, a, e);
            end
        end
        act_q.delete();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_first_draw();
        test_erase_redraw();
        test_clip();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
